// File: rtl/cc_pkg.sv
// Shared definitions for the CC pattern driver: pattern field layout,
// entry counts, error codes and the driver FSM state encoding.
package cc_pkg;

    // Packed pattern width and per-entry field widths
    localparam int PAT_W   = 223;
    localparam int COLOR_W = 3;
    localparam int POS_W   = 3;
    localparam int ACT_W   = 2;
    localparam int SCORE_W = 7;

    // Entry counts
    localparam int N_COLOR  = 36;
    localparam int N_STRIPE = 4;
    localparam int N_ACTION = 10;

    // MSB of each field group; entry 0 sits at the top of its group
    localparam int COLOR_HI      = 222;
    localparam int STRIPE_ROW_HI = 114;
    localparam int STRIPE_COL_HI = 102;
    localparam int STRIPE_TYP_HI = 90;
    localparam int ACT_ROW_HI    = 86;
    localparam int ACT_COL_HI    = 56;
    localparam int ACT_HI        = 26;
    localparam int SCORE_HI      = 6;

    // Result codes
    localparam logic [2:0] ERR_OK          = 3'd0;
    localparam logic [2:0] ERR_SCORE       = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT     = 3'd2;
    localparam logic [2:0] ERR_MULTI_VALID = 3'd3;
    localparam logic [2:0] ERR_IDLE_SCORE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CANDY,
        S_GAP,
        S_ACTION,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

endpackage

// File: rtl/cc_field_mux.sv
// Selects one color / stripe / action entry out of the latched pattern.
// Ports: pattern (latched vector), color_idx (0..35, low 2 bits pick the
// stripe entry), act_idx (0..9); outputs the selected fields plus the
// expected score. Indexes outside the valid range return 0.
module cc_field_mux
    import cc_pkg::*;
(
    input  logic [PAT_W-1:0]   pattern,
    input  logic [5:0]         color_idx,
    input  logic [3:0]         act_idx,
    output logic [2:0]         color,
    output logic [5:0]         stripe_pos,
    output logic               stripe_type,
    output logic [5:0]         act_pos,
    output logic [1:0]         action,
    output logic [SCORE_W-1:0] exp_score
);

    logic [2:0] colors [64];
    logic [5:0] s_pos  [N_STRIPE];
    logic       s_type [N_STRIPE];
    logic [5:0] a_pos  [16];
    logic [1:0] acts   [16];

    for (genvar i = 0; i < 64; i++) begin : g_color
        if (i < N_COLOR) begin : g_used
            assign colors[i] = pattern[COLOR_HI-COLOR_W*i -: COLOR_W];
        end else begin : g_pad
            assign colors[i] = '0;
        end
    end

    for (genvar i = 0; i < N_STRIPE; i++) begin : g_stripe
        assign s_pos[i]  = {pattern[STRIPE_ROW_HI-POS_W*i -: POS_W],
                            pattern[STRIPE_COL_HI-POS_W*i -: POS_W]};
        assign s_type[i] = pattern[STRIPE_TYP_HI-i];
    end

    for (genvar i = 0; i < 16; i++) begin : g_action
        if (i < N_ACTION) begin : g_used
            assign a_pos[i] = {pattern[ACT_ROW_HI-POS_W*i -: POS_W],
                               pattern[ACT_COL_HI-POS_W*i -: POS_W]};
            assign acts[i]  = pattern[ACT_HI-ACT_W*i -: ACT_W];
        end else begin : g_pad
            assign a_pos[i] = '0;
            assign acts[i]  = '0;
        end
    end

    assign color       = colors[color_idx];
    assign stripe_pos  = s_pos[color_idx[1:0]];
    assign stripe_type = s_type[color_idx[1:0]];
    assign act_pos     = a_pos[act_idx];
    assign action      = acts[act_idx];
    assign exp_score   = pattern[SCORE_HI -: SCORE_W];

endmodule

// File: rtl/cc_pattern_driver.sv
// Drives one packed test pattern into the CC block and checks its score.
// Ports: clk, rst_n (async active-low), start/pattern request, busy/done/
// pass/err_code status, in_valid_1/in_valid_2/in_color/in_starting_pos/
// in_stripe/in_action CC stimulus (all registered), out_valid/out_score
// CC response.
module cc_pattern_driver
    import cc_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 500
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [PAT_W-1:0]   pattern,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2:0]         err_code,
    output logic               in_valid_1,
    output logic               in_valid_2,
    output logic [2:0]         in_color,
    output logic [5:0]         in_starting_pos,
    output logic               in_stripe,
    output logic [1:0]         in_action,
    input  logic               out_valid,
    input  logic [SCORE_W-1:0] out_score
);

    localparam logic [9:0] COLOR_LAST = 10'(N_COLOR - 1);
    localparam logic [9:0] ACT_LAST   = 10'(N_ACTION - 1);
    localparam logic [9:0] STRIPE_N   = 10'(N_STRIPE);
    localparam logic [9:0] GAP_LAST   = 10'(GAP_CYCLES - 1);
    localparam logic [9:0] LAT_LAST   = 10'(TIMEOUT - 1);

    state_t             state, state_n;
    logic [9:0]         cnt, cnt_n;
    logic [PAT_W-1:0]   pat_q, pat_n;
    logic [SCORE_W-1:0] score_q, score_n;
    logic [2:0]         err_n;
    logic               pass_n;
    logic               iv1_n, iv2_n, stripe_n;
    logic [2:0]         color_n;
    logic [5:0]         pos_n;
    logic [1:0]         action_n;

    logic [2:0]         m_color;
    logic [5:0]         m_stripe_pos;
    logic               m_stripe_type;
    logic [5:0]         m_act_pos;
    logic [1:0]         m_action;
    logic [SCORE_W-1:0] m_exp_score;

    // cnt is shared: entry index in CANDY/ACTION, gap count in GAP,
    // response latency in WAIT (0 in the last in_valid_2 cycle).
    cc_field_mux u_mux (
        .pattern     (pat_q),
        .color_idx   (cnt[5:0]),
        .act_idx     (cnt[3:0]),
        .color       (m_color),
        .stripe_pos  (m_stripe_pos),
        .stripe_type (m_stripe_type),
        .act_pos     (m_act_pos),
        .action      (m_action),
        .exp_score   (m_exp_score)
    );

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            cnt             <= '0;
            pat_q           <= '0;
            score_q         <= '0;
            err_code        <= ERR_OK;
            pass            <= 1'b0;
            in_valid_1      <= 1'b0;
            in_valid_2      <= 1'b0;
            in_color        <= '0;
            in_starting_pos <= '0;
            in_stripe       <= 1'b0;
            in_action       <= '0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            pat_q           <= pat_n;
            score_q         <= score_n;
            err_code        <= err_n;
            pass            <= pass_n;
            in_valid_1      <= iv1_n;
            in_valid_2      <= iv2_n;
            in_color        <= color_n;
            in_starting_pos <= pos_n;
            in_stripe       <= stripe_n;
            in_action       <= action_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        pat_n    = pat_q;
        score_n  = score_q;
        err_n    = err_code;
        pass_n   = pass;
        iv1_n    = 1'b0;
        iv2_n    = 1'b0;
        color_n  = '0;
        pos_n    = '0;
        stripe_n = 1'b0;
        action_n = '0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    pat_n   = pattern;
                    err_n   = ERR_OK;
                    pass_n  = 1'b0;
                    cnt_n   = '0;
                    state_n = S_CANDY;
                end
            end
            S_CANDY: begin
                iv1_n   = 1'b1;
                color_n = m_color;
                if (cnt < STRIPE_N) begin
                    pos_n    = m_stripe_pos;
                    stripe_n = m_stripe_type;
                end
                if (cnt == COLOR_LAST) begin
                    cnt_n   = '0;
                    state_n = (GAP_CYCLES > 0) ? S_GAP : S_ACTION;
                end else begin
                    cnt_n = cnt + 10'd1;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = S_ACTION;
                end else begin
                    cnt_n = cnt + 10'd1;
                end
            end
            S_ACTION: begin
                iv2_n    = 1'b1;
                pos_n    = m_act_pos;
                action_n = m_action;
                if (cnt == ACT_LAST) begin
                    cnt_n   = '0;
                    state_n = S_WAIT;
                end else begin
                    cnt_n = cnt + 10'd1;
                end
            end
            S_WAIT: begin
                if (out_valid) begin
                    score_n = out_score;
                    state_n = S_CHECK;
                end else if (cnt == LAT_LAST) begin
                    err_n   = ERR_TIMEOUT;
                    pass_n  = 1'b0;
                    state_n = S_DONE;
                end else if (out_score != '0) begin
                    err_n   = ERR_IDLE_SCORE;
                    pass_n  = 1'b0;
                    state_n = S_DONE;
                end else begin
                    cnt_n = cnt + 10'd1;
                end
            end
            S_CHECK: begin
                if (out_valid) begin
                    err_n = ERR_MULTI_VALID;
                end else if (out_score != '0) begin
                    err_n = ERR_IDLE_SCORE;
                end else if (score_q != m_exp_score) begin
                    err_n = ERR_SCORE;
                end else begin
                    err_n = ERR_OK;
                end
                pass_n  = (err_n == ERR_OK);
                state_n = S_DONE;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cc_pattern_driver.sv
// Self-checking bench for cc_pattern_driver: a CC responder model plus a
// pattern-slicing reference for the expected stimulus stream and result.
module tb_cc_pattern_driver;
    import cc_pkg::*;

    localparam int GAP = 2;
    localparam int TMO = 500;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic             busy, done, pass;
    logic [2:0]       err_code;
    logic             in_valid_1, in_valid_2;
    logic [2:0]       in_color;
    logic [5:0]       in_starting_pos;
    logic             in_stripe;
    logic [1:0]       in_action;
    logic             out_valid;
    logic [6:0]       out_score;

    always #5 clk = ~clk;

    cc_pattern_driver #(.GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .pattern         (pattern),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_code        (err_code),
        .in_valid_1      (in_valid_1),
        .in_valid_2      (in_valid_2),
        .in_color        (in_color),
        .in_starting_pos (in_starting_pos),
        .in_stripe       (in_stripe),
        .in_action       (in_action),
        .out_valid       (out_valid),
        .out_score       (out_score)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Observations of the last run
    int n_v1, n_v2, first_v1, last_v1, first_v2, last_v2, done_cyc;
    int zero_viol, busy_viol;
    bit timed_out;
    logic got_pass;
    logic [2:0] got_err;
    int col_q[$], pos1_q[$], str_q[$], pos2_q[$], act_q[$];

    function automatic int fld(input logic [PAT_W-1:0] p, input int lsb,
                               input int w);
        logic [PAT_W-1:0] t;
        t = p >> lsb;
        return int'(t[6:0]) & ((1 << w) - 1);
    endfunction

    function automatic logic [PAT_W-1:0] put(input logic [PAT_W-1:0] p,
                                             input int lsb, input int w,
                                             input int v);
        logic [PAT_W-1:0] m, x;
        m = (PAT_W'(1) << w) - PAT_W'(1);
        x = PAT_W'(v) & m;
        return (p & ~(m << lsb)) | (x << lsb);
    endfunction

    function automatic logic [PAT_W-1:0] rand_pat();
        logic [223:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom()};
        return t[PAT_W-1:0];
    endfunction

    // Result a correct driver reports for a given CC behaviour
    function automatic int exp_err(input int lat, input int hold,
                                   input int score, input int expect_s,
                                   input int bad_at);
        if (bad_at >= 0 && (lat < 0 || bad_at < lat) && bad_at < TMO)
            return 4;
        if (lat < 0 || lat > TMO - 1) return 2;
        if (hold > 1) return 3;
        if (bad_at == lat + 1) return 4;
        if (score != expect_s) return 1;
        return 0;
    endfunction

    // Starts one run and plays the CC: out_valid for `hold` cycles starting
    // `lat` cycles after the last in_valid_2 (lat<0: never); a stray nonzero
    // out_score at last_v2+bad_at; a second start at cycle restart_at.
    // Returns at the negedge of the done cycle.
    task automatic run(input logic [PAT_W-1:0] pat, input int lat,
                       input int score, input int hold, input int bad_at,
                       input int restart_at);
        col_q.delete(); pos1_q.delete(); str_q.delete();
        pos2_q.delete(); act_q.delete();
        n_v1 = 0; n_v2 = 0; first_v1 = -1; last_v1 = -1;
        first_v2 = -1; last_v2 = -1; done_cyc = -1;
        zero_viol = 0; busy_viol = 0; timed_out = 0;
        got_pass = 1'b0; got_err = 3'd7;
        @(negedge clk);
        pattern = pat;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pattern = ~pat;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (in_valid_1) begin
                n_v1++;
                if (first_v1 < 0) first_v1 = cyc;
                last_v1 = cyc;
                col_q.push_back(int'(in_color));
                pos1_q.push_back(int'(in_starting_pos));
                str_q.push_back(int'(in_stripe));
                if (in_action != 2'd0) zero_viol++;
            end
            if (in_valid_2) begin
                n_v2++;
                if (first_v2 < 0) first_v2 = cyc;
                if (n_v2 == N_ACTION) last_v2 = cyc;
                pos2_q.push_back(int'(in_starting_pos));
                act_q.push_back(int'(in_action));
                if (in_color != 3'd0 || in_stripe) zero_viol++;
            end
            if (in_valid_1 && in_valid_2) zero_viol++;
            if (!in_valid_1 && !in_valid_2 &&
                {in_color, in_starting_pos, in_stripe, in_action} != 12'd0)
                zero_viol++;
            if (done) begin
                done_cyc = cyc;
                got_pass = pass;
                got_err  = err_code;
                if (busy) busy_viol++;
                break;
            end
            if (!busy) busy_viol++;
            out_valid = 1'b0;
            out_score = 7'd0;
            if (last_v2 >= 0) begin
                if (lat >= 0 && cyc >= last_v2 + lat &&
                    cyc < last_v2 + lat + hold) begin
                    out_valid = 1'b1;
                    out_score = 7'(score);
                end
                if (bad_at >= 0 && cyc == last_v2 + bad_at)
                    out_score = 7'd9;
            end
            start = (cyc == restart_at);
        end
        out_valid = 1'b0;
        out_score = 7'd0;
        start = 1'b0;
        if (done_cyc < 0) timed_out = 1;
    endtask

    task automatic test_reset();
        int strobes;
        rst_n = 1'b0; start = 1'b0; pattern = '0;
        out_valid = 1'b0; out_score = 7'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, pass, in_valid_1, in_valid_2} !== 5'b0)
            $display("FAIL reset_ctrl got=%b exp=00000",
                     {busy, done, pass, in_valid_1, in_valid_2});
        else n_pass++;
        n_checks++;
        if ({err_code, in_color, in_starting_pos, in_stripe, in_action}
            !== 15'b0)
            $display("FAIL reset_fields got=%h exp=0",
                     {err_code, in_color, in_starting_pos, in_stripe,
                      in_action});
        else n_pass++;
        rst_n = 1'b1;
        strobes = 0;
        repeat (6) begin
            @(negedge clk);
            if (in_valid_1 || in_valid_2 || busy) strobes++;
        end
        n_checks++;
        if (strobes != 0)
            $display("FAIL reset_quiet got=%0d exp=0", strobes);
        else n_pass++;
    endtask

    task automatic test_golden();
        logic [PAT_W-1:0] p;
        p = put(rand_pat(), 0, 7, 23);
        run(p, 5, 23, 1, -1, -1);
        n_checks++;
        if (timed_out) $display("FAIL golden_done got=none exp=done");
        else n_pass++;
        n_checks++;
        if (n_v1 != N_COLOR || last_v1 - first_v1 + 1 != N_COLOR)
            $display("FAIL golden_v1 got=%0d span=%0d exp=36",
                     n_v1, last_v1 - first_v1 + 1);
        else n_pass++;
        n_checks++;
        if (first_v2 - last_v1 - 1 != GAP)
            $display("FAIL golden_gap got=%0d exp=%0d",
                     first_v2 - last_v1 - 1, GAP);
        else n_pass++;
        n_checks++;
        if (n_v2 != N_ACTION || last_v2 - first_v2 + 1 != N_ACTION)
            $display("FAIL golden_v2 got=%0d exp=10", n_v2);
        else n_pass++;
        n_checks++;
        if (got_pass !== 1'b1 || got_err !== 3'd0)
            $display("FAIL golden_result got=%b/%0d exp=1/0",
                     got_pass, got_err);
        else n_pass++;
        n_checks++;
        if (done_cyc + 1 != 1 + 36 + GAP + 10 + 5 + 2)
            $display("FAIL golden_latency got=%0d exp=%0d",
                     done_cyc + 1, 1 + 36 + GAP + 10 + 5 + 2);
        else n_pass++;
        n_checks++;
        if (busy_viol != 0 || zero_viol != 0)
            $display("FAIL golden_strobes got=%0d/%0d exp=0/0",
                     busy_viol, zero_viol);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || pass !== 1'b1 || err_code !== 3'd0)
                $display("FAIL golden_hold got=%b%b/%0d exp=01/0",
                         done, pass, err_code);
            else n_pass++;
        end
    endtask

    task automatic test_field_map();
        logic [PAT_W-1:0] p;
        int rows [4] = '{1, 3, 5, 2};
        int cols [4] = '{2, 4, 0, 2};
        int typs [4] = '{1, 0, 1, 0};
        int epos [4] = '{10, 28, 40, 18};
        int bad;
        p = rand_pat();
        for (int k = 0; k < 36; k++) p = put(p, 220 - 3 * k, 3, k % 6);
        for (int k = 0; k < 4; k++) begin
            p = put(p, 112 - 3 * k, 3, rows[k]);
            p = put(p, 100 - 3 * k, 3, cols[k]);
            p = put(p, 90 - k, 1, typs[k]);
        end
        run(p, 3, fld(p, 0, 7), 1, -1, -1);
        n_checks++;
        if (col_q.size() != 36)
            $display("FAIL map_count got=%0d exp=36", col_q.size());
        else n_pass++;
        bad = 0;
        for (int k = 0; k < col_q.size(); k++)
            if (col_q[k] != k % 6) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL map_colors got=%0d bad exp=0", bad);
        else n_pass++;
        for (int k = 0; k < 4 && k < pos1_q.size(); k++) begin
            n_checks++;
            if (pos1_q[k] != epos[k] || str_q[k] != typs[k])
                $display("FAIL map_stripe%0d got=%o/%0d exp=%o/%0d", k,
                         pos1_q[k], str_q[k], epos[k], typs[k]);
            else n_pass++;
        end
        bad = 0;
        for (int k = 4; k < pos1_q.size(); k++)
            if (pos1_q[k] != 0 || str_q[k] != 0) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL map_tail got=%0d bad exp=0", bad);
        else n_pass++;
    endtask

    task automatic test_mismatch();
        logic [PAT_W-1:0] p;
        int strobes;
        p = put(rand_pat(), 0, 7, 23);
        run(p, 4, 22, 1, -1, -1);
        n_checks++;
        if (got_pass !== 1'b0 || got_err !== ERR_SCORE)
            $display("FAIL mismatch got=%b/%0d exp=0/1", got_pass, got_err);
        else n_pass++;
        // start raised during the done cycle must be dropped
        start = 1'b1;
        pattern = rand_pat();
        @(negedge clk);
        start = 1'b0;
        strobes = 0;
        repeat (4) begin
            if (busy || in_valid_1) strobes++;
            @(negedge clk);
        end
        n_checks++;
        if (strobes != 0 || err_code !== ERR_SCORE)
            $display("FAIL done_start got=%0d/%0d exp=0/1",
                     strobes, err_code);
        else n_pass++;
    endtask

    task automatic test_timeout();
        run(rand_pat(), -1, 0, 0, -1, -1);
        n_checks++;
        if (got_err !== ERR_TIMEOUT || got_pass !== 1'b0)
            $display("FAIL timeout_err got=%b/%0d exp=0/2", got_pass, got_err);
        else n_pass++;
        n_checks++;
        if (done_cyc - last_v2 != TMO)
            $display("FAIL timeout_len got=%0d exp=%0d",
                     done_cyc - last_v2, TMO);
        else n_pass++;
    endtask

    task automatic test_double_valid();
        logic [PAT_W-1:0] p;
        p = rand_pat();
        run(p, 5, fld(p, 0, 7), 2, -1, -1);
        n_checks++;
        if (got_err !== ERR_MULTI_VALID || got_pass !== 1'b0)
            $display("FAIL double_valid got=%b/%0d exp=0/3",
                     got_pass, got_err);
        else n_pass++;
    endtask

    task automatic test_idle_score();
        logic [PAT_W-1:0] p;
        p = rand_pat();
        run(p, 6, fld(p, 0, 7), 1, 2, -1);
        n_checks++;
        if (got_err !== ERR_IDLE_SCORE || done_cyc - last_v2 != 3)
            $display("FAIL idle_score_wait got=%0d@%0d exp=4@3",
                     got_err, done_cyc - last_v2);
        else n_pass++;
        run(p, 4, fld(p, 0, 7), 1, 5, -1);
        n_checks++;
        if (got_err !== ERR_IDLE_SCORE || done_cyc - last_v2 != 6)
            $display("FAIL idle_score_check got=%0d@%0d exp=4@6",
                     got_err, done_cyc - last_v2);
        else n_pass++;
    endtask

    task automatic test_busy_start();
        logic [PAT_W-1:0] p;
        int bad;
        p = rand_pat();
        run(p, 2, fld(p, 0, 7), 1, -1, 10);
        bad = 0;
        for (int k = 0; k < col_q.size(); k++)
            if (col_q[k] != fld(p, 220 - 3 * k, 3)) bad++;
        n_checks++;
        if (bad != 0 || col_q.size() != 36 || got_err !== ERR_OK)
            $display("FAIL busy_start got=%0d bad/%0d err=%0d exp=0/36/0",
                     bad, col_q.size(), got_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [PAT_W-1:0] p;
        int strobes;
        p = rand_pat();
        @(negedge clk);
        pattern = p;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (in_valid_1 !== 1'b1)
            $display("FAIL midrst_pre got=%b exp=1", in_valid_1);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_valid_1, busy, in_color} !== 5'b0)
            $display("FAIL midrst_async got=%b exp=00000",
                     {in_valid_1, busy, in_color});
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        strobes = 0;
        repeat (5) begin
            @(negedge clk);
            if (in_valid_1 || in_valid_2 || busy) strobes++;
        end
        n_checks++;
        if (strobes != 0)
            $display("FAIL midrst_quiet got=%0d exp=0", strobes);
        else n_pass++;
        run(p, 7, fld(p, 0, 7), 1, -1, -1);
        n_checks++;
        if (n_v1 != 36 || n_v2 != 10 || got_err !== ERR_OK ||
            got_pass !== 1'b1)
            $display("FAIL midrst_rerun got=%0d/%0d/%0d exp=36/10/0",
                     n_v1, n_v2, got_err);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [PAT_W-1:0] p;
        int lat, hold, score, bad_at, e, bad, ep, es, edone;
        for (int it = 0; it < 6; it++) begin
            p = rand_pat();
            lat = int'($urandom_range(0, 12));
            hold = ($urandom_range(0, 3) == 0) ? 2 : 1;
            score = ($urandom_range(0, 1) == 0) ? fld(p, 0, 7)
                                                 : int'($urandom_range(0, 127));
            bad_at = ($urandom_range(0, 3) == 0) ? lat + 1 : -1;
            e = exp_err(lat, hold, score, fld(p, 0, 7), bad_at);
            run(p, lat, score, hold, bad_at, -1);
            bad = 0;
            for (int k = 0; k < col_q.size(); k++) begin
                ep = (k < 4) ? fld(p, 112 - 3 * k, 3) * 8 +
                               fld(p, 100 - 3 * k, 3) : 0;
                es = (k < 4) ? fld(p, 90 - k, 1) : 0;
                if (col_q[k] != fld(p, 220 - 3 * k, 3) || pos1_q[k] != ep ||
                    str_q[k] != es) bad++;
            end
            for (int j = 0; j < pos2_q.size(); j++) begin
                ep = fld(p, 84 - 3 * j, 3) * 8 + fld(p, 54 - 3 * j, 3);
                if (pos2_q[j] != ep || act_q[j] != fld(p, 25 - 2 * j, 2))
                    bad++;
            end
            n_checks++;
            if (bad != 0 || col_q.size() != 36 || pos2_q.size() != 10 ||
                zero_viol != 0)
                $display("FAIL rand%0d_stream got=%0d bad %0d/%0d z=%0d exp=0 36/10 0",
                         it, bad, col_q.size(), pos2_q.size(), zero_viol);
            else n_pass++;
            n_checks++;
            if (last_v2 != N_COLOR + GAP + N_ACTION)
                $display("FAIL rand%0d_lastv2 got=%0d exp=%0d", it, last_v2,
                         N_COLOR + GAP + N_ACTION);
            else n_pass++;
            n_checks++;
            if (int'(got_err) != e || got_pass !== (e == 0))
                $display("FAIL rand%0d_err got=%0d/%b exp=%0d", it,
                         got_err, got_pass, e);
            else n_pass++;
            edone = (e == 2) ? TMO : lat + 2;
            n_checks++;
            if (done_cyc - last_v2 != edone)
                $display("FAIL rand%0d_done got=%0d exp=%0d", it,
                         done_cyc - last_v2, edone);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_field_map();
        test_mismatch();
        test_timeout();
        test_double_valid();
        test_idle_score();
        test_busy_start();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cc_pattern_driver.md
CC_PATTERN_DRIVER -- requirements
Module: cc_pattern_driver

Interface
REQ-001 Parameters: GAP_CYCLES default 2, the idle cycles between the last in_valid_1 and the first in_valid_2; TIMEOUT default 500, the maximum wait in cycles for out_valid.
REQ-002 Ports: clk  in  1  sole clock; all logic on posedge.
REQ-003 Ports: rst_n  in  1  asynchronous reset, active-low.
REQ-004 Ports: start  in  1  single-cycle request to run one pattern.
REQ-005 Ports: pattern  in  223  packed test vector, sampled only when start is accepted.
REQ-006 Ports: busy  out  1  high from start acceptance until done.
REQ-007 Ports: done  out  1  one-cycle pulse marking the end of a run.
REQ-008 Ports: pass  out  1  result of the run, valid with done.
REQ-009 Ports: err_code  out  3  failure code, valid with done: 0 ok, 1 score mismatch, 2 timeout, 3 out_valid high for more than 1 cycle, 4 out_score nonzero while out_valid is low.
REQ-010 Ports: in_valid_1, in_valid_2  out  1 each  CC input strobes.
REQ-011 Ports: in_color  out  3; in_starting_pos  out  6; in_stripe  out  1; in_action  out  2.  CC input fields.
REQ-012 Ports: out_valid  in  1; out_score  in  7.  CC response.

Function
REQ-013 Pattern fields, MSB first:
  - colors [222:115]: color i at [222-3i : 220-3i], i = 0..35.
  - stripe rows [114:103] and stripe cols [102:91]: 3 bits per entry, 4 entries each.
  - stripe types [90:87].
  - action rows [86:57] and action cols [56:27]: 3 bits per entry, 10 entries each.
  - actions [26:7]: 2 bits per entry, 10 entries.
  - expected score [6:0].
REQ-014 FSM states: IDLE, CANDY, GAP, ACTION, WAIT, CHECK, DONE.
REQ-015 IDLE: start=1 latches pattern into a 223-bit register, sets busy, and moves to CANDY on the next cycle. start while busy is ignored.
REQ-016 CANDY: in_valid_1=1 for exactly 36 consecutive cycles; cycle k drives color k.
  - For k<4: in_starting_pos = {row_k, col_k} and in_stripe = type bit [90-k].
  - For k>=4: in_starting_pos and in_stripe are driven to 0.
REQ-017 GAP: all CC inputs are 0 for GAP_CYCLES cycles.
REQ-018 ACTION: in_valid_2=1 for exactly 10 cycles; cycle j drives in_starting_pos = {arow_j, acol_j} and in_action = act_j.
REQ-019 Every CC input is registered, and every field is 0 whenever its strobe is low.
REQ-020 WAIT: a 10-bit latency counter clears at the last in_valid_2 cycle and increments each cycle.
  - out_valid=1: capture out_score; go to CHECK.
  - Counter reaches TIMEOUT-1 without out_valid: err 2, go to DONE.
  - out_score nonzero while out_valid=0: err 4, go to DONE.
REQ-021 CHECK, one cycle:
  - out_valid still 1: err 3.
  - Otherwise out_score != 0: err 4.
  - Otherwise captured score != expected: err 1.
  - Otherwise: err 0.
  Then go to DONE.
REQ-022 DONE: done=1 and pass=(err_code==0) for one cycle; busy drops in the same cycle; next state is IDLE.
REQ-023 err_code and pass hold their values until the next accepted start.
REQ-024 A start arriving in the DONE cycle is ignored; the earliest accepted start is in the IDLE cycle after done.
REQ-025 Throughput: a run with response latency L takes 1 + 36 + GAP_CYCLES + 10 + L + 2 cycles from start to done.

Reset
REQ-026 rst_n low forces, asynchronously:
  - state to IDLE;
  - all outputs, the counters and the pattern register to 0;
  - err_code to 0.
  This applies mid-run as well.
REQ-027 After rst_n rises, no CC strobe asserts until a new start is accepted.

Structure
REQ-028 Shared package cc_pkg holds:
  - the pattern field offsets and widths (REQ-013);
  - the entry counts 36, 4 and 10;
  - the err_code constants;
  - the FSM state encoding.
  CC and its bench import cc_pkg.
REQ-029 One sub-module, cc_field_mux, which selects the color, stripe and action fields from the pattern register by index; the FSM and counters stay in the top module.

Verification
REQ-030 Golden run: CC model answers score 7'd23 five cycles after the last in_valid_2; pattern expects 23 -> done with pass=1, err_code=0; exactly 36 in_valid_1 cycles, then 2 idle cycles, then 10 in_valid_2 cycles.
REQ-031 Field mapping: pattern with color k = k mod 6, stripe entries {row,col,type} = {1,2,1},{3,4,0},{5,0,1},{2,2,0} -> in_color sequence 0,1,2,3,4,5,0,...; in_starting_pos = 6'o12,6'o34,6'o50,6'o22 with in_stripe 1,0,1,0 in cycles 0-3, then 0.
REQ-032 Model returns 22 while 23 is expected -> err_code=1, pass=0.
REQ-033 Model never asserts out_valid -> done exactly TIMEOUT cycles after the last in_valid_2 with err_code=2; model holds out_valid 2 cycles -> err_code=3.
REQ-034 rst_n pulsed low in cycle 20 of CANDY -> in_valid_1 drops immediately and busy=0; a start after release runs a complete, correct sequence; a start pulsed while busy changes nothing.
